// File: rtl/keccak_absorb_unit.sv
// keccak_absorb_unit: assembles byte-keep beats into padded rate-sized Keccak blocks for the core
module keccak_absorb_unit #(
    parameter int DWIDTH            = 256,
    parameter int BLOCK_BITS        = 1600,
    parameter int MAX_SPILL         = 31,
    parameter int MODE_SEL_WIDTH    = 2,
    parameter int RATE_WIDTH        = 11,
    parameter int BYTE_ABSORB_WIDTH = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [MODE_SEL_WIDTH-1:0]    keccak_mode_i,
    input  logic [RATE_WIDTH-1:0]        rate_i,
    input  logic                         start_i,
    input  logic [DWIDTH-1:0]            s_data_i,
    input  logic [DWIDTH/8-1:0]          s_keep_i,
    input  logic                         s_last_i,
    input  logic                         s_valid_i,
    output logic                         s_ready_o,
    output logic [BLOCK_BITS-1:0]        block_o,
    output logic                         block_valid_o,
    output logic                         block_last_o,
    input  logic                         block_ready_i,
    output logic [BYTE_ABSORB_WIDTH-1:0] ptr_o,
    output logic                         busy_o
);
    localparam int NB  = DWIDTH / 8;
    localparam int NBL = BLOCK_BITS / 8;
    localparam int NW  = $clog2(NB + 1);
    localparam int SW  = $clog2(MAX_SPILL + 1);
    localparam int PW  = BYTE_ABSORB_WIDTH + 1;
    localparam logic [MODE_SEL_WIDTH-1:0] SHAKE128 = 2;
    localparam logic [MODE_SEL_WIDTH-1:0] SHAKE256 = 3;

    typedef enum logic [1:0] {IDLE, FILL, PAD, EMIT} state_t;

    state_t                       r_state;
    logic [MODE_SEL_WIDTH-1:0]    r_mode;
    logic [RATE_WIDTH-1:0]        r_rate;
    logic [BLOCK_BITS-1:0]        r_buf;
    logic [MAX_SPILL*8-1:0]       r_carry;
    logic [BYTE_ABSORB_WIDTH-1:0] r_ptr;
    logic [SW-1:0]                r_spill;
    logic                         r_pend;
    logic                         r_s_ready;
    logic                         r_block_valid;
    logic                         r_block_last;
    logic                         r_busy;

    logic [BYTE_ABSORB_WIDTH-1:0] w_r;
    logic [NW-1:0]                w_n;
    logic [PW-1:0]                w_sum;
    logic                         w_full;
    logic [7:0]                   w_dsuf;

    assign w_r    = BYTE_ABSORB_WIDTH'(r_rate >> 3);
    assign w_sum  = {1'b0, r_ptr} + PW'(w_n);
    assign w_full = w_sum >= {1'b0, w_r};
    assign w_dsuf = (r_mode == SHAKE128 || r_mode == SHAKE256) ? 8'h1F : 8'h06;

    assign block_o       = r_buf;
    assign block_valid_o = r_block_valid;
    assign block_last_o  = r_block_last;
    assign s_ready_o     = r_s_ready;
    assign ptr_o         = r_ptr;
    assign busy_o        = r_busy;

    // Length of the leading run of keep ones; bits after the first zero are ignored
    always_comb begin
        w_n = '0;
        for (int j = 0; j < NB; j++)
            if (s_keep_i[j] && int'(w_n) == j) w_n = NW'(j + 1);
    end

    // Absorb FSM: fill buffer, spill straddling bytes into the carry, pad, hand off blocks
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= IDLE;
            r_mode        <= '0;
            r_rate        <= '0;
            r_buf         <= '0;
            r_carry       <= '0;
            r_ptr         <= '0;
            r_spill       <= '0;
            r_pend        <= 1'b0;
            r_s_ready     <= 1'b0;
            r_block_valid <= 1'b0;
            r_block_last  <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start_i) begin
                    r_mode    <= keccak_mode_i;
                    r_rate    <= rate_i;
                    r_buf     <= '0;
                    r_ptr     <= '0;
                    r_spill   <= '0;
                    r_pend    <= 1'b0;
                    r_s_ready <= 1'b1;
                    r_busy    <= 1'b1;
                    r_state   <= FILL;
                end
                FILL: if (s_valid_i) begin
                    for (int j = 0; j < NB; j++)
                        if (j < int'(w_n)) begin
                            if (int'(r_ptr) + j < int'(w_r))
                                r_buf[8*(int'(r_ptr)+j) +: 8] <= s_data_i[8*j +: 8];
                            else
                                r_carry[8*(int'(r_ptr)+j-int'(w_r)) +: 8] <= s_data_i[8*j +: 8];
                        end
                    if (w_full) begin
                        r_spill       <= SW'(w_sum - {1'b0, w_r});
                        r_pend        <= s_last_i;
                        r_block_last  <= 1'b0;
                        r_block_valid <= 1'b1;
                        r_s_ready     <= 1'b0;
                        r_state       <= EMIT;
                    end else begin
                        r_ptr <= r_ptr + BYTE_ABSORB_WIDTH'(w_n);
                        if (s_last_i) begin
                            r_s_ready <= 1'b0;
                            r_state   <= PAD;
                        end
                    end
                end
                PAD: begin
                    // Suffix and final 0x80 are merged per byte so ptr==R-1 yields 0x86/0x9F
                    for (int b = 0; b < NBL; b++)
                        r_buf[8*b +: 8] <= r_buf[8*b +: 8]
                                         ^ (b == int'(r_ptr) ? w_dsuf : 8'h00)
                                         ^ (b == int'(w_r) - 1 ? 8'h80 : 8'h00);
                    r_block_last  <= 1'b1;
                    r_block_valid <= 1'b1;
                    r_state       <= EMIT;
                end
                EMIT: if (block_ready_i) begin
                    r_buf <= '0;
                    for (int j = 0; j < MAX_SPILL; j++)
                        if (j < int'(r_spill)) r_buf[8*j +: 8] <= r_carry[8*j +: 8];
                    r_ptr         <= BYTE_ABSORB_WIDTH'(r_spill);
                    r_spill       <= '0;
                    r_block_valid <= 1'b0;
                    if (r_block_last) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (r_pend) begin
                        r_pend  <= 1'b0;
                        r_state <= PAD;
                    end else begin
                        r_s_ready <= 1'b1;
                        r_state   <= FILL;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_keccak_absorb_unit.sv
// tb_keccak_absorb_unit: randomized scoreboard bench against a byte-queue sponge padding model
module tb_keccak_absorb_unit;
    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic [1:0]    keccak_mode_i;
    logic [10:0]   rate_i;
    logic          start_i;
    logic [255:0]  s_data_i;
    logic [31:0]   s_keep_i;
    logic          s_last_i;
    logic          s_valid_i;
    logic          s_ready_o;
    logic [1599:0] block_o;
    logic          block_valid_o;
    logic          block_last_o;
    logic          block_ready_i;
    logic [7:0]    ptr_o;
    logic          busy_o;

    typedef struct packed {
        logic [1599:0] blk;
        logic          last;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] msg[$];
    int         sizes[$];
    int         n_chk = 0;
    int         n_pass = 0;
    bit         hold = 1'b0;

    keccak_absorb_unit dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .keccak_mode_i(keccak_mode_i), .rate_i(rate_i),
        .start_i(start_i), .s_data_i(s_data_i), .s_keep_i(s_keep_i), .s_last_i(s_last_i),
        .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .block_o(block_o),
        .block_valid_o(block_valid_o), .block_last_o(block_last_o),
        .block_ready_i(block_ready_i), .ptr_o(ptr_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic chk_blk(input string nm, input logic [1599:0] a, input logic [1599:0] e);
        int d = 0;
        for (int i = 199; i >= 0; i--) if (a[8*i +: 8] !== e[8*i +: 8]) d = i;
        chk($sformatf("%s byte %0d", nm, d), 64'(a[8*d +: 8]), 64'(e[8*d +: 8]));
    endtask

    function automatic int rate_of(input logic [1:0] m);
        return m == 2'd1 ? 576 : m == 2'd2 ? 1344 : 1088;
    endfunction

    // Reference sponge padding: message || suffix || 0* || 0x80 split into R-byte blocks
    task automatic push_model(input logic [1:0] mode);
        int         r = rate_of(mode) / 8;
        int         l = msg.size();
        int         nb = l / r + 1;
        logic [7:0] p[$];
        exp_t       e;
        p = msg;
        while (p.size() < nb * r) p.push_back(8'h00);
        p[l] = p[l] ^ (mode[1] ? 8'h1F : 8'h06);
        p[nb*r-1] = p[nb*r-1] ^ 8'h80;
        for (int k = 0; k < nb; k++) begin
            e.blk = '0;
            for (int b = 0; b < r; b++) e.blk[8*b +: 8] = p[k*r+b];
            e.last = (k == nb - 1);
            sb.push_back(e);
        end
    endtask

    task automatic do_start(input logic [1:0] mode);
        keccak_mode_i = mode;
        rate_i = 11'(rate_of(mode));
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
    endtask

    task automatic send_beat(input int n, input bit last, input int idx);
        logic [255:0] d;
        logic [31:0]  k;
        bit           ok;
        int           c = 0;
        for (int j = 0; j < 32; j++) begin
            if (j < n) d[8*j +: 8] = msg[idx+j];
            else d[8*j +: 8] = 8'($urandom);
            k[j] = (j < n);
        end
        if (n < 31) k = k | ($urandom & ~((32'd1 << (n + 1)) - 1));
        s_data_i = d;
        s_keep_i = k;
        s_last_i = last;
        s_valid_i = 1'b1;
        do begin
            ok = s_ready_o;
            @(posedge clk_i); #1;
            c++;
        end while (!ok && c < 300);
        chk("beat accepted", 64'(ok), 64'd1);
        s_valid_i = 1'b0;
        s_last_i = 1'b0;
    endtask

    task automatic run_msg(input logic [1:0] mode, input bit hold_test);
        int            idx = 0;
        int            c = 0;
        logic [1599:0] cap;
        push_model(mode);
        do_start(mode);
        foreach (sizes[i]) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk_i); #1; end
            send_beat(sizes[i], i == sizes.size() - 1, idx);
            idx += sizes[i];
        end
        if (hold_test) begin
            while (!block_valid_o && c < 50) begin @(posedge clk_i); #1; c++; end
            cap = block_o;
            repeat (10) begin
                @(posedge clk_i); #1;
                chk("hold valid", 64'(block_valid_o), 64'd1);
                chk("hold s_ready", 64'(s_ready_o), 64'd0);
                chk_blk("hold block", block_o, cap);
            end
            hold = 1'b0;
        end
        c = 0;
        while (busy_o && c < 3000) begin @(posedge clk_i); #1; c++; end
        chk("idle after msg", 64'(busy_o), 64'd0);
        chk("scoreboard drained", 64'(sb.size()), 64'd0);
    endtask

    task automatic check_zero(input string nm);
        chk_blk({nm, " block_o"}, block_o, '0);
        chk({nm, " block_valid"}, 64'(block_valid_o), 64'd0);
        chk({nm, " block_last"}, 64'(block_last_o), 64'd0);
        chk({nm, " s_ready"}, 64'(s_ready_o), 64'd0);
        chk({nm, " ptr"}, 64'(ptr_o), 64'd0);
        chk({nm, " busy"}, 64'(busy_o), 64'd0);
    endtask

    // Core-side ready: random backpressure unless a hold is requested
    initial begin
        block_ready_i = 1'b0;
        forever begin
            @(posedge clk_i); #1;
            block_ready_i = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: compare each transferred block against the scoreboard and check stability
    exp_t          e_m;
    logic          pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [1599:0] pb = '0;
    initial forever begin
        @(negedge clk_i);
        if (!rst_ni) pv = 1'b0;
        else begin
            if (pv && !pr) begin
                chk("valid held", 64'(block_valid_o), 64'd1);
                chk_blk("block stable", block_o, pb);
                chk("last stable", 64'(block_last_o), 64'(pl));
            end
            if (block_valid_o && block_ready_i) begin
                chk("block expected", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) begin
                    e_m = sb.pop_front();
                    chk("block_last", 64'(block_last_o), 64'(e_m.last));
                    chk_blk("block", block_o, e_m.blk);
                end
            end
            pv = block_valid_o;
            pr = block_ready_i;
            pb = block_o;
            pl = block_last_o;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          rem;
        int          n;
        int          l;
        logic [1:0]  m;
        keccak_mode_i = '0; rate_i = '0; start_i = 1'b0; s_data_i = '0;
        s_keep_i = '0; s_last_i = 1'b0; s_valid_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check_zero("reset");
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        check_zero("idle");

        msg.delete(); sizes = '{0};
        run_msg(2'd0, 1'b0);

        msg = '{8'h61, 8'h62, 8'h63}; sizes = '{3};
        run_msg(2'd0, 1'b0);

        msg.delete(); repeat (168) msg.push_back(8'($urandom));
        sizes = '{32, 32, 32, 32, 32, 8};
        run_msg(2'd2, 1'b0);

        msg.delete(); repeat (96) msg.push_back(8'($urandom));
        sizes = '{32, 32, 32};
        run_msg(2'd1, 1'b0);

        msg.delete(); repeat (71) msg.push_back(8'($urandom));
        sizes = '{32, 32, 7};
        hold = 1'b1;
        run_msg(2'd1, 1'b1);

        msg.delete(); repeat (64) msg.push_back(8'($urandom));
        do_start(2'd0);
        send_beat(32, 1'b0, 0);
        send_beat(32, 1'b0, 32);
        chk("ptr after 2 beats", 64'(ptr_o), 64'd64);
        rst_ni = 1'b0;
        #1;
        check_zero("mid reset");
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        msg = '{8'h61, 8'h62, 8'h63}; sizes = '{3};
        run_msg(2'd0, 1'b0);

        repeat (25) begin
            m = 2'($urandom_range(0, 3));
            l = $urandom_range(0, 400);
            if ($urandom_range(0, 3) == 0) l = (rate_of(m) / 8) * $urandom_range(1, 2);
            msg.delete(); repeat (l) msg.push_back(8'($urandom));
            sizes.delete();
            rem = l;
            while (rem > 0) begin
                n = $urandom_range(0, 1) ? 32 : $urandom_range(1, 32);
                if (n > rem) n = rem;
                sizes.push_back(n);
                rem -= n;
            end
            if (l == 0 || $urandom_range(0, 3) == 0) sizes.push_back(0);
            run_msg(m, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
